// File: rtl/rd_control.sv
// rd_control: diagonal-wavefront read sequencer for a bank of row memories
//    feeding a systolic array. Bank i starts reading i cycles after bank 0,
//    each bank reads num_rows consecutive offsets starting at base_addr.
// Ports:
//    i_clk       clock, all state on rising edge
//    i_reset     synchronous active-high reset
//    i_active    start request, honoured only in IDLE
//    i_base_addr first row offset shared by all banks
//    i_num_rows  rows to read per bank (0 finishes immediately)
//    o_rd_en     per-bank read enable
//    o_rd_addr   packed per-bank 8-bit offsets, lane i = [8i+7:8i]
//    o_busy      high during every RUN cycle
//    o_done      one-cycle completion pulse
module rd_control #(
   parameter int width_height = 16,
   localparam int data_width = 8 * width_height
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_active,
   input  logic [7:0]              i_base_addr,
   input  logic [7:0]              i_num_rows,
   output logic [width_height-1:0] o_rd_en,
   output logic [data_width-1:0]   o_rd_addr,
   output logic                    o_busy,
   output logic                    o_done
);
   // step counter must reach num_rows + width_height - 2 without overflow
   localparam int tw = $clog2(256 + width_height) + 1;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t                  r_state, w_state_n;
   logic [tw-1:0]           r_t, w_t_n;
   logic [7:0]              r_base, w_base_n;
   logic [7:0]              r_len, w_len_n;
   logic [width_height-1:0] r_rd_en, w_en_n;
   logic [data_width-1:0]   r_rd_addr, w_addr_n;
   logic                    r_busy, r_done;
   always_comb begin
      w_state_n = r_state;
      w_t_n     = r_t;
      w_base_n  = r_base;
      w_len_n   = r_len;
      case (r_state)
         IDLE: if (i_active) begin
            w_base_n  = i_base_addr;
            w_len_n   = i_num_rows;
            w_t_n     = '0;
            w_state_n = (i_num_rows == 8'd0) ? FIN : RUN;
         end
         RUN: begin
            // last step is t = L + width_height - 2
            if (r_t + tw'(1) == tw'(r_len) + tw'(width_height - 1)) w_state_n = FIN;
            else w_t_n = r_t + tw'(1);
         end
         default: begin
            w_state_n = IDLE;
            w_t_n     = '0;
         end
      endcase
   end
   // outputs are computed from the next state so they land in flops
   // aligned with the cycle they describe
   always_comb begin
      w_en_n   = '0;
      w_addr_n = '0;
      for (int i = 0; i < width_height; i++) begin
         if (w_state_n == RUN && w_t_n >= tw'(i) && w_t_n < tw'(i) + tw'(w_len_n)) begin
            w_en_n[i]           = 1'b1;
            w_addr_n[8*i +: 8]  = w_base_n + w_t_n[7:0] - 8'(i);
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_t       <= '0;
         r_base    <= '0;
         r_len     <= '0;
         r_rd_en   <= '0;
         r_rd_addr <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_t       <= w_t_n;
         r_base    <= w_base_n;
         r_len     <= w_len_n;
         r_rd_en   <= w_en_n;
         r_rd_addr <= w_addr_n;
         r_busy    <= (w_state_n == RUN);
         r_done    <= (w_state_n == FIN);
      end
   end
   assign o_rd_en   = r_rd_en;
   assign o_rd_addr = r_rd_addr;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
endmodule
